// File: rtl/charnum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | charnum_if : start/done handshake and operand/result bundle for charnum    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface charnum_if #(
    parameter int DIGITS = 10,
    parameter int WORD_W = 30,
    parameter int BYTE_W = 6
);
    logic                       start;
    logic                       mode;
    logic [WORD_W-1:0]          in_bin;
    logic [DIGITS*BYTE_W-1:0]   in_chars;
    logic                       busy;
    logic                       done;
    logic [DIGITS*BYTE_W-1:0]   out_chars;
    logic [WORD_W-1:0]          out_bin;
    logic                       ovf;

    modport master (
        output start, mode, in_bin, in_chars,
        input  busy, done, out_chars, out_bin, ovf
    );

    modport slave (
        input  start, mode, in_bin, in_chars,
        output busy, done, out_chars, out_bin, ovf
    );
endinterface
`default_nettype wire

// File: rtl/charnum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | charnum : multicycle MIX CHAR/NUM radix converter, one decimal digit/clock |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module charnum #(
    parameter int DIGITS    = 10,
    parameter int WORD_W    = 30,
    parameter int BYTE_W    = 6,
    parameter int ZERO_CODE = 30
) (
    input  logic     clk,
    input  logic     rst_n,
    charnum_if.slave bus
);
    localparam int                 c_CW    = WORD_W + 4;
    localparam int                 c_TW    = DIGITS * BYTE_W;
    localparam int                 c_NW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_NW-1:0]    c_LAST  = c_NW'(DIGITS - 1);
    localparam logic [c_CW-1:0]    c_TEN_C = c_CW'(10);
    localparam logic [BYTE_W-1:0]  c_TEN_B = BYTE_W'(10);
    localparam logic [WORD_W-1:0]  c_TEN_W = WORD_W'(10);

    // Number of decimal digits in the largest WORD_W-bit value.
    function automatic int digits_needed();
        logic [WORD_W-1:0] m;
        int                n;
        m = '1;
        n = 0;
        while (m != '0) begin
            m = m / c_TEN_W;
            n = n + 1;
        end
        return n;
    endfunction

    // Powers that do not fit the compare width saturate; they always yield d=0.
    function automatic logic [c_CW-1:0] pow10(input int e);
        logic [c_CW+3:0] v;
        logic            sat;
        v   = (c_CW+4)'(1);
        sat = 1'b0;
        for (int i = 0; i < e; i++) begin
            if (!sat) begin
                v   = v * (c_CW+4)'(10);
                sat = |v[c_CW+3:c_CW];
            end
        end
        return sat ? '1 : v[c_CW-1:0];
    endfunction

    localparam int c_NEED = digits_needed();

    if (DIGITS < c_NEED) begin : g_bad_digits
        $fatal(1, "charnum: DIGITS too small to represent every WORD_W-bit value");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_mode;
    logic [c_NW-1:0]    r_cnt;
    logic [WORD_W-1:0]  r_rem;
    logic [c_TW-1:0]    r_src;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [c_TW-1:0]    r_out_chars;
    logic [WORD_W-1:0]  r_out_bin;

    logic [c_CW-1:0]    w_pow [DIGITS];
    logic [c_CW-1:0]    w_p;
    logic [3:0]         w_digit;
    logic [WORD_W-1:0]  w_dp;
    logic [BYTE_W-1:0]  w_code;
    logic [BYTE_W-1:0]  w_byte;
    logic [BYTE_W-1:0]  w_mod;
    logic [c_CW-1:0]    w_sum;

    for (genvar k = 0; k < DIGITS; k++) begin : g_pow
        assign w_pow[k] = pow10(DIGITS - 1 - k);
    end

    assign w_p = w_pow[r_cnt];

    // CHAR digit: count how many multiples of the current power fit in the remainder.
    always_comb begin
        w_digit = 4'd0;
        for (int j = 1; j < 10; j++) begin
            if ((c_CW+4)'(j) * {4'b0000, w_p} <= {8'b0000_0000, r_rem}) begin
                w_digit = 4'(j);
            end
        end
    end

    // d*P never exceeds the remainder, so the low WORD_W bits are exact.
    assign w_dp   = w_p[WORD_W-1:0] * WORD_W'(w_digit);
    assign w_code = BYTE_W'(32'(w_digit) + ZERO_CODE);

    assign w_byte = r_src[c_TW-1 -: BYTE_W];
    assign w_mod  = w_byte % c_TEN_B;
    assign w_sum  = {4'b0000, r_out_bin} * c_TEN_C + c_CW'(w_mod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_src       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_chars <= '0;
            r_out_bin   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_mode  <= bus.mode;
                        r_rem   <= bus.in_bin;
                        r_src   <= bus.in_chars;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        if (bus.mode) begin
                            r_out_bin <= '0;
                        end else begin
                            r_out_chars <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_mode) begin
                        r_out_bin <= w_sum[WORD_W-1:0];
                        r_ovf     <= r_ovf | (|w_sum[c_CW-1:WORD_W]);
                        r_src     <= r_src << BYTE_W;
                    end else begin
                        r_rem       <= r_rem - w_dp;
                        r_out_chars <= (r_out_chars << BYTE_W) | c_TW'(w_code);
                    end
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_chars = r_out_chars;
    assign bus.out_bin   = r_out_bin;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_charnum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_charnum : directed table-driven bench for the charnum CHAR/NUM unit     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_charnum;
    localparam int DIGITS = 10;
    localparam int WORD_W = 30;
    localparam int BYTE_W = 6;
    localparam int TW     = DIGITS * BYTE_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    charnum_if #(.DIGITS(DIGITS), .WORD_W(WORD_W), .BYTE_W(BYTE_W)) bus  ();
    charnum_if #(.DIGITS(DIGITS), .WORD_W(WORD_W), .BYTE_W(BYTE_W)) bus0 ();

    charnum #(.DIGITS(DIGITS), .WORD_W(WORD_W), .BYTE_W(BYTE_W), .ZERO_CODE(30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    charnum #(.DIGITS(DIGITS), .WORD_W(WORD_W), .BYTE_W(BYTE_W), .ZERO_CODE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    typedef int blist_t [10];

    typedef struct {
        logic              mode;
        logic [WORD_W-1:0] bin;
        logic [TW-1:0]     chars;
        logic [TW-1:0]     exp_chars;
        logic [WORD_W-1:0] exp_bin;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [TW-1:0] pk(input blist_t b);
        logic [TW-1:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v = (v << BYTE_W) | TW'(b[i] & 63);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one conversion on the default-offset unit; lat counts edges from E0 to the done cycle.
    task automatic run_conv(input logic m, input logic [WORD_W-1:0] b, input logic [TW-1:0] c,
                            output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.in_bin = b; bus.in_chars = c;
        @(posedge clk); #1;
        lat = 1;
        check("busy_after_start", bus.busy, 1);
        do begin
            @(negedge clk); bus.start = 1'b0;
            @(posedge clk); #1; lat++;
        end while (!bus.done && lat < 40);
        check("done_seen", bus.done, 1);
    endtask

    task automatic run0(input logic [WORD_W-1:0] b, output int lat);
        @(negedge clk);
        bus0.start = 1'b1; bus0.in_bin = b;
        @(posedge clk); #1;
        lat = 1;
        do begin
            @(negedge clk); bus0.start = 1'b0;
            @(posedge clk); #1; lat++;
        end while (!bus0.done && lat < 40);
        check("z0_done_seen", bus0.done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat;
        int             dcount;
        int             d1, d2, ndone;
        logic [TW-1:0]  last_chars;
        logic [WORD_W-1:0] last_bin;

        bus.start  = 1'b0; bus.mode  = 1'b0; bus.in_bin  = '0; bus.in_chars  = '0;
        bus0.start = 1'b0; bus0.mode = 1'b0; bus0.in_bin = '0; bus0.in_chars = '0;

        vecs[0] = '{1'b0, 30'd12977,      '0, pk('{30,30,30,30,30,31,32,39,37,37}), '0, 1'b0};
        vecs[1] = '{1'b0, 30'd1073741823, '0, pk('{31,30,37,33,37,34,31,38,32,33}), '0, 1'b0};
        vecs[2] = '{1'b1, '0, pk('{30,30,30,30,30,30,30,31,42,63}), '0, 30'd123, 1'b0};
        vecs[3] = '{1'b1, '0, pk('{39,39,39,39,39,39,39,39,39,39}), '0, 30'd336323583, 1'b1};
        vecs[4] = '{1'b0, 30'd0,          '0, pk('{30,30,30,30,30,30,30,30,30,30}), '0, 1'b0};
        vecs[5] = '{1'b1, '0, pk('{1,0,7,3,7,4,1,8,2,3}), '0, 30'd1073741823, 1'b0};
        vecs[6] = '{1'b1, '0, pk('{1,0,7,3,7,4,1,8,2,4}), '0, 30'd0, 1'b1};
        vecs[7] = '{1'b0, 30'd5,          '0, pk('{30,30,30,30,30,30,30,30,30,35}), '0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_busy",  bus.busy, 0);
        check("reset_done",  bus.done, 0);
        check("reset_ovf",   bus.ovf, 0);
        check("reset_chars", bus.out_chars, 0);
        check("reset_bin",   bus.out_bin, 0);

        last_chars = '0;
        last_bin   = '0;
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].mode, vecs[i].bin, vecs[i].chars, lat);
            check($sformatf("v%0d_latency", i), lat, 11);
            if (vecs[i].mode) begin
                check($sformatf("v%0d_out_bin", i), bus.out_bin, vecs[i].exp_bin);
                check($sformatf("v%0d_chars_held", i), bus.out_chars, last_chars);
                last_bin = vecs[i].exp_bin;
            end else begin
                check($sformatf("v%0d_out_chars", i), bus.out_chars, vecs[i].exp_chars);
                check($sformatf("v%0d_bin_held", i), bus.out_bin, last_bin);
                last_chars = vecs[i].exp_chars;
            end
            check($sformatf("v%0d_ovf", i), bus.ovf, vecs[i].exp_ovf);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_one_cycle", i), bus.done, 0);
            check($sformatf("v%0d_idle", i), bus.busy, 0);
        end

        // Asynchronous reset in the middle of a CHAR conversion
        run_conv(1'b1, '0, pk('{39,39,39,39,39,39,39,39,39,39}), lat);
        check("pre_reset_ovf", bus.ovf, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.in_bin = 30'd12977;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy",  bus.busy, 0);
        check("async_rst_done",  bus.done, 0);
        check("async_rst_ovf",   bus.ovf, 0);
        check("async_rst_chars", bus.out_chars, 0);
        check("async_rst_bin",   bus.out_bin, 0);
        @(negedge clk); rst_n = 1'b1;
        dcount = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) dcount++;
        end
        check("no_done_after_reset", dcount, 0);

        // Raw-digit unit (ZERO_CODE = 0)
        run0(30'd12977, lat);
        check("z0_latency", lat, 11);
        check("z0_12977", bus0.out_chars, pk('{0,0,0,0,0,1,2,9,7,7}));
        run0(30'd0, lat);
        check("z0_zero", bus0.out_chars, 0);

        // Start during busy is ignored; held start gives back-to-back conversions
        d1 = -1; d2 = -1; ndone = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.in_bin = 30'd12977;
        @(posedge clk);
        for (int e = 1; e <= 22; e++) begin
            @(negedge clk);
            if (e == 1) bus.start = 1'b0;
            if (e == 3) begin bus.start = 1'b1; bus.mode = 1'b1; bus.in_bin = 30'd999; end
            if (e == 4) bus.start = 1'b0;
            if (e == 11) begin bus.start = 1'b1; bus.mode = 1'b0; bus.in_bin = 30'd1073741823; end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (d1 < 0) d1 = e; else if (d2 < 0) d2 = e;
            end
            if (e == 3)  check("busy_at_ignored_start", bus.busy, 1);
            if (e == 10) check("ignored_start_result", bus.out_chars,
                               pk('{30,30,30,30,30,31,32,39,37,37}));
            if (e == 11) check("b2b_accept_busy", bus.busy, 1);
            if (e == 21) check("b2b_result", bus.out_chars,
                               pk('{31,30,37,33,37,34,31,38,32,33}));
            if (e == 22) check("b2b_third_busy", bus.busy, 1);
        end
        check("b2b_done_count", ndone, 2);
        check("b2b_first_done_edge", d1, 10);
        check("b2b_second_done_edge", d2, 21);

        @(negedge clk); bus.start = 1'b0;
        dcount = 0;
        while (!bus.done && dcount < 20) begin
            @(posedge clk); #1; dcount++;
        end
        check("drain_done_seen", bus.done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
